// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Targets are kept as word addresses and re-expanded on prediction.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    logic [ENTRIES-1:0] valid;
    logic [TW-1:0]      tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX-1:0] lk_idx;
    logic [TW-1:0]  lk_tag;
    logic           lk_hit;

    logic [IDX-1:0] up_idx;
    logic [TW-1:0]  up_tag;
    logic           up_hit;
    logic [1:0]     up_ctr;

    logic           unused_bits;

    assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

    assign lk_idx = if_pc[IDX+1:2];
    assign lk_tag = if_pc[31:IDX+2];
    assign lk_hit = valid[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign pred_taken   = lk_hit && ctr_q[lk_idx][1];
    assign pred_next_pc = pred_taken ? {tgt_q[lk_idx], 2'b00}
                                     : if_pc + 32'd4;

    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[31:IDX+2];
    assign up_hit = valid[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr = ctr_q[up_idx];

    // Flush wins over a same-cycle update; only valid bits are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (flush) begin
            valid <= '0;
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    tgt_q[up_idx] <= upd_target[31:2];
                    if (up_ctr != 2'b11)
                        ctr_q[up_idx] <= up_ctr + 2'd1;
                end else if (up_ctr != 2'b00) begin
                    ctr_q[up_idx] <= up_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                valid[up_idx] <= 1'b1;
                tag_q[up_idx] <= up_tag;
                tgt_q[up_idx] <= upd_target[31:2];
                ctr_q[up_idx] <= 2'b10;
            end
        end
    end

endmodule
